// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions for the receive path (uart_rx) and the transmit path
// (uart_tx).
//   uart_rx_state_t             : receiver FSM state encoding
//   UART_DATA_BITS              : data bits per frame (8N1)
//   UART_DEFAULT_CYCLES_PER_BIT : 50 MHz / 115200 baud
//   maj3()                      : 2-of-3 majority helper for sample voting
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_BITS              = 8;
  localparam int UART_DEFAULT_CYCLES_PER_BIT = 434;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } uart_rx_state_t;

  // Two-of-three majority.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer for an asynchronous single-bit input.
//   RESET_VAL : value both flops take in reset
//   clk       : sampling clock
//   rst       : synchronous active-high reset
//   d_i       : asynchronous input
//   q_o       : synchronized output (two clk cycles of latency)
// -----------------------------------------------------------------------------
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  // Synchronizer chain: bit 0 may go metastable, bit 1 is the settled copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {2{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver with a single-entry AXI-stream master output.
// Oversamples rx with clk, samples each bit at its centre, delivers the byte on
// tdata/tvalid and flags framing errors and dropped bytes.
//
// Parameter:
//   cycles_per_bit : clk cycles per bit, legal 4 .. 65535
// Ports:
//   clk           : sole clock, rising edge
//   rst           : synchronous active-high reset
//   rx            : asynchronous serial input, idle high
//   tready        : downstream ready
//   tvalid        : byte available (registered)
//   tdata         : received byte (registered)
//   framing_error : one-cycle pulse, stop bit sampled low
//   overflow      : one-cycle pulse, completed byte dropped
//
// Build option:
//   UART_RX_MAJORITY_VOTE_EN : each sample is the 2-of-3 majority of the line
//   at centre-1, centre and centre+1 (one extra cycle of latency; needs
//   cycles_per_bit >= 8).
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int cycles_per_bit = UART_DEFAULT_CYCLES_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       tready,
  output logic       tvalid,
  output logic [7:0] tdata,
  output logic       framing_error,
  output logic       overflow
);

  localparam int CW = $clog2(cycles_per_bit);
  localparam logic [CW-1:0] BIT_LOAD = CW'(cycles_per_bit - 1);

  // With voting the decision is taken one cycle after the centre, once the
  // centre+1 sample exists, so the first countdown is one cycle longer.
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [CW-1:0] START_LOAD = CW'(cycles_per_bit / 2);
`else
  localparam logic [CW-1:0] START_LOAD = CW'(cycles_per_bit / 2 - 1);
`endif

  if (cycles_per_bit < 4 || cycles_per_bit > 65535) begin : g_bad_cpb
    $error("uart_rx: cycles_per_bit out of range 4..65535");
  end
`ifdef UART_RX_MAJORITY_VOTE_EN
  if (cycles_per_bit < 8) begin : g_bad_cpb_vote
    $error("uart_rx: majority voting needs cycles_per_bit >= 8");
  end
`endif

  logic           rxs_s;
  logic           sample_s;
  logic           deliver_s;
  logic           frame_err_s;

  uart_rx_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     shift_q, shift_d;

  logic           tvalid_q, tvalid_d;
  logic [7:0]     tdata_q, tdata_d;
  logic           framing_error_q, framing_error_d;
  logic           overflow_q, overflow_d;

  uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rxs_s)
  );

`ifdef UART_RX_MAJORITY_VOTE_EN
  // hist_q[0] = rxs one cycle ago (centre), hist_q[1] = two cycles ago (centre-1).
  logic [1:0] hist_q;

  // Short history of the synchronized line for the vote.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rxs_s};
    end
  end

  assign sample_s = maj3(hist_q[1], hist_q[0], rxs_s);
`else
  assign sample_s = rxs_s;
`endif

  // Frame decoder: next state, bit timing and data assembly.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    deliver_s   = 1'b0;
    frame_err_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rxs_s) begin
          state_d = START;
          cnt_d   = START_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!sample_s) begin
          state_d = DATA;
          cnt_d   = BIT_LOAD;
          idx_d   = 3'd0;
        end else begin
          // Start bit gone by mid-bit: treat as a glitch.
          state_d = IDLE;
        end
      end
      DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          shift_d[idx_q] = sample_s;
          cnt_d          = BIT_LOAD;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (sample_s) begin
          deliver_s = 1'b1;
          state_d   = IDLE;
        end else begin
          frame_err_s = 1'b1;
          state_d     = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        // A held-low line (break) must not be decoded as repeated start bits.
        if (rxs_s) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output stage: single-entry buffer; a byte arriving into a full,
  // un-acknowledged buffer is dropped.
  always_comb begin
    tvalid_d        = tvalid_q;
    tdata_d         = tdata_q;
    overflow_d      = 1'b0;
    framing_error_d = frame_err_s;
    if (deliver_s) begin
      if (!tvalid_q || tready) begin
        tdata_d  = shift_q;
        tvalid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (tready) begin
      tvalid_d = 1'b0;
    end else begin
      tvalid_d = tvalid_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      idx_q           <= 3'd0;
      shift_q         <= 8'h00;
      tvalid_q        <= 1'b0;
      tdata_q         <= 8'h00;
      framing_error_q <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      idx_q           <= idx_d;
      shift_q         <= shift_d;
      tvalid_q        <= tvalid_d;
      tdata_q         <= tdata_d;
      framing_error_q <= framing_error_d;
      overflow_q      <= overflow_d;
    end
  end

  assign tvalid        = tvalid_q;
  assign tdata         = tdata_q;
  assign framing_error = framing_error_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx: bit-bangs 8N1 frames onto rx and checks the
// received bytes, handshake behaviour and error pulses.
// -----------------------------------------------------------------------------
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB  = 434;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       rx     = 1'b1;
  logic       tready = 1'b0;
  logic       tvalid;
  logic [7:0] tdata;
  logic       framing_error;
  logic       overflow;

  uart_rx #(.cycles_per_bit(CPB)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .tready        (tready),
    .tvalid        (tvalid),
    .tdata         (tdata),
    .framing_error (framing_error),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Monitor state, sampled on the falling edge.
  int         cyc      = 0;
  int         rx_n     = 0;
  int         fe_n     = 0;
  int         ov_n     = 0;
  int         v_cycles = 0;
  int         rise_cyc = -1;
  logic       tv_prev  = 1'b0;
  logic [7:0] rx_bytes [0:63];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    tv_prev <= tvalid;
    if (tvalid && !tv_prev) rise_cyc <= cyc;
    if (tvalid) v_cycles <= v_cycles + 1;
    if (tvalid && tready) begin
      rx_bytes[rx_n[5:0]] <= tdata;
      rx_n <= rx_n + 1;
    end
    if (framing_error) fe_n <= fe_n + 1;
    if (overflow) ov_n <= ov_n + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(CPB);
  endtask

  // Leaves rx at the stop-bit level when done.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_bit);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(4);
    checks++; if (tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b want 0", tvalid); else passed++;
    checks++; if (tdata !== 8'h00) $display("FAIL reset_tdata: got %h want 00", tdata); else passed++;
    checks++; if (framing_error !== 1'b0) $display("FAIL reset_fe: got %b want 0", framing_error); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL reset_ov: got %b want 0", overflow); else passed++;
    rst = 1'b0;
    tick(4);
    checks++; if (dut.state_q !== IDLE) $display("FAIL reset_state: got %0d want IDLE", dut.state_q); else passed++;
  endtask

  task automatic test_single();
    int n0, f0, o0, v0, c0;
    tready = 1'b1;
    tick(CPB);
    n0 = rx_n; f0 = fe_n; o0 = ov_n; v0 = v_cycles; c0 = cyc;
    send_frame(8'hA5, 1'b1);
    tick(20);
    checks++; if (rx_n - n0 !== 1) $display("FAIL single_count: got %0d want 1", rx_n - n0); else passed++;
    checks++; if (rx_bytes[n0[5:0]] !== 8'hA5) $display("FAIL single_data: got %h want a5", rx_bytes[n0[5:0]]); else passed++;
    checks++; if (fe_n !== f0) $display("FAIL single_fe: got %0d want %0d", fe_n, f0); else passed++;
    checks++; if (ov_n !== o0) $display("FAIL single_ov: got %0d want %0d", ov_n, o0); else passed++;
    checks++; if (v_cycles - v0 !== 1) $display("FAIL single_valid_cycles: got %0d want 1", v_cycles - v0); else passed++;
    checks++;
    if (rise_cyc !== c0 + 3 + HALF + 9 * CPB + LAT)
      $display("FAIL single_latency: got %0d want %0d", rise_cyc - c0, 3 + HALF + 9 * CPB + LAT);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] tbl [7] = '{8'h00, 8'hFF, 8'h3C, 8'h81, 8'h5A, 8'h7E, 8'hC3};
    int n0, f0, o0;
    tready = 1'b1;
    n0 = rx_n; f0 = fe_n; o0 = ov_n;
    for (int i = 0; i < 7; i++) send_frame(tbl[i], 1'b1);
    tick(20);
    checks++; if (rx_n - n0 !== 7) $display("FAIL b2b_count: got %0d want 7", rx_n - n0); else passed++;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (rx_bytes[(n0 + i) % 64] !== tbl[i])
        $display("FAIL b2b_data[%0d]: got %h want %h", i, rx_bytes[(n0 + i) % 64], tbl[i]);
      else passed++;
    end
    checks++; if (fe_n !== f0) $display("FAIL b2b_fe: got %0d want %0d", fe_n, f0); else passed++;
    checks++; if (ov_n !== o0) $display("FAIL b2b_ov: got %0d want %0d", ov_n, o0); else passed++;
  endtask

  task automatic test_overflow();
    int n0, o0;
    tready = 1'b0;
    n0 = rx_n; o0 = ov_n;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(20);
    checks++; if (tvalid !== 1'b1) $display("FAIL ovf_tvalid_held: got %b want 1", tvalid); else passed++;
    checks++; if (tdata !== 8'h11) $display("FAIL ovf_tdata_held: got %h want 11", tdata); else passed++;
    checks++; if (ov_n - o0 !== 1) $display("FAIL ovf_pulses: got %0d want 1", ov_n - o0); else passed++;
    checks++; if (rx_n !== n0) $display("FAIL ovf_no_consume: got %0d want %0d", rx_n, n0); else passed++;
    tready = 1'b1;
    tick(5);
    checks++; if (rx_n - n0 !== 1) $display("FAIL ovf_drain_count: got %0d want 1", rx_n - n0); else passed++;
    checks++; if (rx_bytes[n0[5:0]] !== 8'h11) $display("FAIL ovf_drain_data: got %h want 11", rx_bytes[n0[5:0]]); else passed++;
    checks++; if (tvalid !== 1'b0) $display("FAIL ovf_drain_tvalid: got %b want 0", tvalid); else passed++;
  endtask

  task automatic test_framing();
    int n0, f0, o0;
    tready = 1'b1;
    n0 = rx_n; f0 = fe_n; o0 = ov_n;
    send_frame(8'h3C, 1'b0);
    tick(3 * CPB);
    rx = 1'b1;
    tick(CPB);
    checks++; if (fe_n - f0 !== 1) $display("FAIL frm_fe_pulses: got %0d want 1", fe_n - f0); else passed++;
    checks++; if (rx_n !== n0) $display("FAIL frm_no_byte: got %0d want %0d", rx_n, n0); else passed++;
    send_frame(8'h5A, 1'b1);
    tick(20);
    checks++; if (rx_n - n0 !== 1) $display("FAIL frm_next_count: got %0d want 1", rx_n - n0); else passed++;
    checks++; if (rx_bytes[n0[5:0]] !== 8'h5A) $display("FAIL frm_next_data: got %h want 5a", rx_bytes[n0[5:0]]); else passed++;
    checks++; if (fe_n - f0 !== 1) $display("FAIL frm_fe_total: got %0d want 1", fe_n - f0); else passed++;
    checks++; if (ov_n !== o0) $display("FAIL frm_ov: got %0d want %0d", ov_n, o0); else passed++;
  endtask

  task automatic test_glitch();
    int n0, f0;
    n0 = rx_n; f0 = fe_n;
    rx = 1'b0;
    tick(CPB / 4);
    rx = 1'b1;
    tick(CPB);
    checks++; if (rx_n !== n0) $display("FAIL glitch_no_byte: got %0d want %0d", rx_n, n0); else passed++;
    checks++; if (tvalid !== 1'b0) $display("FAIL glitch_tvalid: got %b want 0", tvalid); else passed++;
    checks++; if (fe_n !== f0) $display("FAIL glitch_fe: got %0d want %0d", fe_n, f0); else passed++;
    checks++; if (dut.state_q !== IDLE) $display("FAIL glitch_state: got %0d want IDLE", dut.state_q); else passed++;
  endtask

  task automatic test_reset_mid();
    int n0, f0;
    tready = 1'b0;
    send_frame(8'h42, 1'b1);
    tick(20);
    checks++; if (tvalid !== 1'b1) $display("FAIL rstmid_held_before: got %b want 1", tvalid); else passed++;
    // 0xFF frame cut off half-way through bit 4.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx = 1'b1;
    tick(HALF);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    checks++; if (tvalid !== 1'b0) $display("FAIL rstmid_tvalid: got %b want 0", tvalid); else passed++;
    checks++; if (tdata !== 8'h00) $display("FAIL rstmid_tdata: got %h want 00", tdata); else passed++;
    tick(CPB);
    tready = 1'b1;
    n0 = rx_n; f0 = fe_n;
    send_frame(8'h81, 1'b1);
    tick(6 * CPB);
    checks++; if (rx_n - n0 !== 1) $display("FAIL rstmid_count: got %0d want 1", rx_n - n0); else passed++;
    checks++; if (rx_bytes[n0[5:0]] !== 8'h81) $display("FAIL rstmid_data: got %h want 81", rx_bytes[n0[5:0]]); else passed++;
    checks++; if (fe_n !== f0) $display("FAIL rstmid_fe: got %0d want %0d", fe_n, f0); else passed++;
  endtask

`ifdef UART_RX_MAJORITY_VOTE_EN
  task automatic test_majority();
    logic [9:0] f;
    int n0;
    f = {1'b1, 8'h96, 1'b0};
    tready = 1'b1;
    n0 = rx_n;
    for (int k = 0; k < 10; k++) begin
      rx = f[k];
      tick(HALF);
      rx = ~f[k];
      tick(1);
      rx = f[k];
      tick(CPB - HALF - 1);
    end
    rx = 1'b1;
    tick(20);
    checks++; if (rx_n - n0 !== 1) $display("FAIL vote_count: got %0d want 1", rx_n - n0); else passed++;
    checks++; if (rx_bytes[n0[5:0]] !== 8'h96) $display("FAIL vote_data: got %h want 96", rx_bytes[n0[5:0]]); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_framing();
    test_glitch();
    test_reset_mid();
`ifdef UART_RX_MAJORITY_VOTE_EN
    test_majority();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
